parking_gate_arbiter: RTL
=========================

// Module: parking_gate_arbiter
// PURPOSE
//  Sequences the car_enter_exit datapath: turns level requests from the entry and exit gate
//  sensors into single-cycle car_enter/car_exit pulses with a valid car_sel.
//  Allocates the lowest free slot on entry, validates exit requests against slot occupancy,
//  arbitrates simultaneous entry/exit requests and times the gate-open window.
//  Sits between the gate sensors/buttons and car_enter_exit.
// PARAMETERS
//  GATE_CYCLES  4  cycles a gate stays open after a granted transaction (legal range 2..15)
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-high reset
//  entry_req       in   1  entry sensor; level, held until entry_ack
//  exit_req        in   1  exit request; level, held until exit_ack
//  exit_sel        in   3  car id to release (3'b001..3'b011); sampled with exit_req
//  occupied        in   3  {car3_state,car2_state,car1_state} from the datapath
//  car_enter       out  1  one-cycle enter pulse to the datapath
//  car_exit        out  1  one-cycle exit pulse to the datapath
//  car_sel         out  3  slot id for the pulse: 3'b001, 3'b010 or 3'b011
//  entry_ack       out  1  one-cycle ack; entry granted
//  exit_ack        out  1  one-cycle ack; exit processed (granted or rejected)
//  exit_err        out  1  high with exit_ack when the exit is rejected
//  entry_gate_open out  1  entry barrier drive
//  exit_gate_open  out  1  exit barrier drive
//  lot_full        out  1  combinational: &occupied
//  free_count      out  2  combinational: number of zero bits in occupied
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, gate timer=0, last_grant=ENTRY. All registered
//    outputs are 0: car_enter, car_exit, car_sel, acks, exit_err and both gate_open signals.
//    Any open gate closes immediately.
//  FSM states: IDLE, ISSUE_ENTER, ISSUE_EXIT, REJECT, GATE_ENTRY, GATE_EXIT.
//  IDLE: requests are sampled here only. Candidates:
//    - entry is eligible when entry_req=1 and lot_full=0.
//    - exit is pending when exit_req=1.
//  Arbitration in IDLE:
//    - If exactly one candidate, it wins.
//    - If both are candidates, the one opposite to last_grant wins.
//    - last_grant updates on each ISSUE_* and on REJECT (counted as an exit grant).
//    - A full lot makes entry ineligible. A held entry_req waits with no ack until a slot frees.
//  Exit check in IDLE: exit_sel must be in 1..3 and occupied[exit_sel-1] must be 1.
//    Pass -> ISSUE_EXIT. Fail -> REJECT.
//  ISSUE_ENTER (1 cycle): car_enter=1, entry_ack=1,
//    car_sel = lowest-indexed zero bit of occupied (slot 1 first), next state GATE_ENTRY.
//  ISSUE_EXIT (1 cycle): car_exit=1, exit_ack=1, car_sel=exit_sel, next state GATE_EXIT.
//  REJECT (1 cycle): exit_ack=1, exit_err=1. No pulse, no gate. Next state IDLE.
//  GATE_ENTRY / GATE_EXIT: the matching gate_open=1 for exactly GATE_CYCLES cycles,
//    then return to IDLE. New requests are not sampled during this window.
//    GATE_CYCLES >= 2 guarantees occupied reflects the issued pulse before the next IDLE.
//  Latency: request seen in IDLE at edge N -> pulse and ack during cycle N+1
//    -> gate open in cycles N+2 .. N+1+GATE_CYCLES.
//  car_sel holds its last value outside ISSUE_*. It returns to 0 only on reset.
//  car_enter and car_exit are never high together. At most one ack per cycle.
//  A request dropped before its ack is simply lost. A request still high after its ack
//    is treated as new in the next IDLE. Requesters must drop the request on ack.
// TESTING
//  1. Reset, occupied=000, entry_req=1 held until ack:
//     -> car_enter pulse with car_sel=001, entry_ack, entry_gate_open high for 4 cycles.
//  2. occupied=011, entry_req=1:
//     -> car_sel=011 (slot 3). Then occupied=111, entry_req=1: lot_full=1, free_count=0,
//        no ack. Then occupied=101 -> grant with car_sel=010.
//  3. occupied=010, exit_req=1, exit_sel=010:
//     -> car_exit pulse, car_sel=010, exit_ack, exit_gate_open 4 cycles.
//     exit_sel=001 -> exit_ack+exit_err, no pulse. exit_sel=000 or 100 -> same rejection.
//  4. entry_req and exit_req rise together, occupied=001, exit_sel=001:
//     -> exit served first (last_grant=ENTRY after reset), then entry after the gate window.
//     Repeat simultaneous requests -> grants alternate.
//  5. Reset asserted mid GATE_ENTRY:
//     -> gate_open drops the same cycle, all outputs 0, FSM in IDLE.
//     After release, a held entry_req is granted with the normal 1-cycle latency.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Turns level entry/exit requests from the gate sensors into
//               single-cycle car_enter/car_exit pulses with a valid car_sel.
//               Picks the lowest free slot on entry, validates exit requests
//               against slot occupancy, alternates between simultaneous
//               entry/exit requests and times the gate-open window.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_sel,
  input  logic [2:0] occupied,
  output logic       car_enter,
  output logic       car_exit,
  output logic [2:0] car_sel,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       lot_full,
  output logic [1:0] free_count
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE_ENTER = 3'd1,
    S_ISSUE_EXIT  = 3'd2,
    S_REJECT      = 3'd3,
    S_GATE_ENTRY  = 3'd4,
    S_GATE_EXIT   = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_ENTRY = 1'b0,
    GRANT_EXIT  = 1'b1
  } grant_t;

  // The timer is loaded as the gate opens, so it counts the remaining
  // open cycles after the current one.
  localparam logic [3:0] C_GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t     state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] car_sel_q, car_sel_d;
  logic       car_enter_q, car_enter_d;
  logic       car_exit_q, car_exit_d;
  logic       entry_ack_q, entry_ack_d;
  logic       exit_ack_q, exit_ack_d;
  logic       exit_err_q, exit_err_d;
  logic       entry_gate_open_q, entry_gate_open_d;
  logic       exit_gate_open_q, exit_gate_open_d;

  logic       entry_eligible;
  logic       exit_valid;
  logic [2:0] free_slot_sel;

  assign lot_full       = &occupied;
  assign free_count     = {1'b0, ~occupied[0]} + {1'b0, ~occupied[1]} + {1'b0, ~occupied[2]};
  assign entry_eligible = entry_req && !lot_full;

  // Lowest free slot id (slot 1 first); only used when the lot is not full.
  always_comb begin
    free_slot_sel = 3'd3;
    if (!occupied[0]) begin
      free_slot_sel = 3'd1;
    end else if (!occupied[1]) begin
      free_slot_sel = 3'd2;
    end
  end

  // An exit is valid only for ids 1..3 whose slot is currently occupied.
  always_comb begin
    exit_valid = 1'b0;
    case (exit_sel)
      3'd1:    exit_valid = occupied[0];
      3'd2:    exit_valid = occupied[1];
      3'd3:    exit_valid = occupied[2];
      default: exit_valid = 1'b0;
    endcase
  end

  // Next-state and registered-output logic; pulses and acks default low.
  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    timer_d           = timer_q;
    car_sel_d         = car_sel_q;
    car_enter_d       = 1'b0;
    car_exit_d        = 1'b0;
    entry_ack_d       = 1'b0;
    exit_ack_d        = 1'b0;
    exit_err_d        = 1'b0;
    entry_gate_open_d = 1'b0;
    exit_gate_open_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Entry wins when it is the only candidate, or when both compete
        // and the previous grant went to the exit side.
        if (entry_eligible && (!exit_req || last_grant_q == GRANT_EXIT)) begin
          state_d      = S_ISSUE_ENTER;
          last_grant_d = GRANT_ENTRY;
          car_enter_d  = 1'b1;
          entry_ack_d  = 1'b1;
          car_sel_d    = free_slot_sel;
        end else if (exit_req) begin
          // A rejected exit still counts as an exit grant for fairness.
          last_grant_d = GRANT_EXIT;
          exit_ack_d   = 1'b1;
          if (exit_valid) begin
            state_d    = S_ISSUE_EXIT;
            car_exit_d = 1'b1;
            car_sel_d  = exit_sel;
          end else begin
            state_d    = S_REJECT;
            exit_err_d = 1'b1;
          end
        end
      end
      S_ISSUE_ENTER: begin
        state_d           = S_GATE_ENTRY;
        timer_d           = C_GATE_LOAD;
        entry_gate_open_d = 1'b1;
      end
      S_ISSUE_EXIT: begin
        state_d          = S_GATE_EXIT;
        timer_d          = C_GATE_LOAD;
        exit_gate_open_d = 1'b1;
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      S_GATE_ENTRY: begin
        if (timer_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d           = timer_q - 4'd1;
          entry_gate_open_d = 1'b1;
        end
      end
      S_GATE_EXIT: begin
        if (timer_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d          = timer_q - 4'd1;
          exit_gate_open_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset closes both gates immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      last_grant_q      <= GRANT_ENTRY;
      timer_q           <= 4'd0;
      car_sel_q         <= 3'd0;
      car_enter_q       <= 1'b0;
      car_exit_q        <= 1'b0;
      entry_ack_q       <= 1'b0;
      exit_ack_q        <= 1'b0;
      exit_err_q        <= 1'b0;
      entry_gate_open_q <= 1'b0;
      exit_gate_open_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      timer_q           <= timer_d;
      car_sel_q         <= car_sel_d;
      car_enter_q       <= car_enter_d;
      car_exit_q        <= car_exit_d;
      entry_ack_q       <= entry_ack_d;
      exit_ack_q        <= exit_ack_d;
      exit_err_q        <= exit_err_d;
      entry_gate_open_q <= entry_gate_open_d;
      exit_gate_open_q  <= exit_gate_open_d;
    end
  end

  assign car_enter       = car_enter_q;
  assign car_exit        = car_exit_q;
  assign car_sel         = car_sel_q;
  assign entry_ack       = entry_ack_q;
  assign exit_ack        = exit_ack_q;
  assign exit_err        = exit_err_q;
  assign entry_gate_open = entry_gate_open_q;
  assign exit_gate_open  = exit_gate_open_q;

endmodule
`default_nettype wire
